// File: rtl/sap1_pkg.sv
// Shared constants for the SAP-1 controller: opcodes, T-state indices and control-word bit positions.
package sap1_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_LDA = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0010;
    localparam logic [OP_W-1:0] OP_OUT = 4'b1110;
    localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

    localparam int T1 = 0;
    localparam int T2 = 1;
    localparam int T3 = 2;
    localparam int T4 = 3;
    localparam int T5 = 4;
    localparam int T6 = 5;

    localparam int CW_PC_INC    = 0;
    localparam int CW_PC_OUT    = 1;
    localparam int CW_MAR_IN    = 2;
    localparam int CW_RAM_OUT   = 3;
    localparam int CW_INSTR_IN  = 4;
    localparam int CW_INSTR_OUT = 5;
    localparam int CW_A_IN      = 6;
    localparam int CW_A_OUT     = 7;
    localparam int CW_B_IN      = 8;
    localparam int CW_ALU_SUB   = 9;
    localparam int CW_ALU_OUT   = 10;
    localparam int CW_OUT_IN    = 11;
    localparam int CW_W         = 12;

    typedef logic [CW_W-1:0] ctrl_word_t;

    // Instructions that touch memory and use the full T4..T6 execute window.
    function automatic logic is_mem_op(input logic [OP_W-1:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// One-hot T-state ring counter with synchronous reset, hold and early wrap back to T1.
module sap1_ring_counter #(
    parameter int NUM_T = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold_i,
    input  logic             wrap_i,
    output logic [NUM_T-1:0] t_o
);

    localparam logic [NUM_T-1:0] FIRST = {{(NUM_T-1){1'b0}}, 1'b1};

    logic [NUM_T-1:0] t_q;
    logic [NUM_T-1:0] t_d;

    always_comb begin
        t_d = {t_q[NUM_T-2:0], t_q[NUM_T-1]};
        if (hold_i) begin
            t_d = t_q;
        end else if (wrap_i) begin
            t_d = FIRST;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t_q <= FIRST;
        end else begin
            t_q <= t_d;
        end
    end

    assign t_o = t_q;

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 controller-sequencer: T1..T6 ring, opcode latch, halt flag and Moore strobe decode.
// Optional build macro SAP1_VAR_CYCLE_EN: OUT and NOP instructions wrap to T1 after T4.
module sap1_controller
    import sap1_pkg::*;
#(
    parameter int OPCODE_W = OP_W,
    parameter int NUM_T    = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode_in,
    output logic                pc_inc,
    output logic                pc_out,
    output logic                mar_in,
    output logic                ram_out,
    output logic                instr_in,
    output logic                instr_out,
    output logic                a_in,
    output logic                a_out,
    output logic                b_in,
    output logic                alu_sub,
    output logic                alu_out,
    output logic                out_in,
    output logic                halt,
    output logic [NUM_T-1:0]    t_state
);

    logic [OPCODE_W-1:0] op_q, op_d;
    logic                halt_q, halt_d;
    logic [NUM_T-1:0]    t_q;
    logic                wrap_early;
    ctrl_word_t          cw;

    sap1_ring_counter #(.NUM_T(NUM_T)) u_ring (
        .clk    (clk),
        .rst    (rst),
        .hold_i (halt_q),
        .wrap_i (wrap_early),
        .t_o    (t_q)
    );

`ifdef SAP1_VAR_CYCLE_EN
    assign wrap_early = t_q[T4] && !is_mem_op(op_q);
`else
    assign wrap_early = 1'b0;
`endif

    // Opcode is sampled only on the edge leaving T3; HLT raises halt on that same edge so it reads 1 throughout T4.
    always_comb begin
        op_d   = op_q;
        halt_d = halt_q;
        if (t_q[T3] && !halt_q) begin
            op_d = opcode_in;
            if (opcode_in == OP_HLT) begin
                halt_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            halt_q <= 1'b0;
        end else begin
            op_q   <= op_d;
            halt_q <= halt_d;
        end
    end

    always_comb begin
        cw = '0;
        if (!rst && !halt_q) begin
            if (t_q[T1]) begin
                cw[CW_PC_OUT] = 1'b1;
                cw[CW_MAR_IN] = 1'b1;
            end
            if (t_q[T2]) begin
                cw[CW_PC_INC] = 1'b1;
            end
            if (t_q[T3]) begin
                cw[CW_RAM_OUT]  = 1'b1;
                cw[CW_INSTR_IN] = 1'b1;
            end
            if (t_q[T4]) begin
                case (op_q)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        cw[CW_INSTR_OUT] = 1'b1;
                        cw[CW_MAR_IN]    = 1'b1;
                    end
                    OP_OUT: begin
                        cw[CW_A_OUT]  = 1'b1;
                        cw[CW_OUT_IN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            if (t_q[T5]) begin
                case (op_q)
                    OP_LDA: begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_A_IN]    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_B_IN]    = 1'b1;
                        cw[CW_ALU_SUB] = (op_q == OP_SUB);
                    end
                    default: ;
                endcase
            end
            if (t_q[T6]) begin
                case (op_q)
                    OP_ADD, OP_SUB: begin
                        cw[CW_ALU_OUT] = 1'b1;
                        cw[CW_A_IN]    = 1'b1;
                        cw[CW_ALU_SUB] = (op_q == OP_SUB);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign pc_inc    = cw[CW_PC_INC];
    assign pc_out    = cw[CW_PC_OUT];
    assign mar_in    = cw[CW_MAR_IN];
    assign ram_out   = cw[CW_RAM_OUT];
    assign instr_in  = cw[CW_INSTR_IN];
    assign instr_out = cw[CW_INSTR_OUT];
    assign a_in      = cw[CW_A_IN];
    assign a_out     = cw[CW_A_OUT];
    assign b_in      = cw[CW_B_IN];
    assign alu_sub   = cw[CW_ALU_SUB];
    assign alu_out   = cw[CW_ALU_OUT];
    assign out_in    = cw[CW_OUT_IN];
    assign halt      = halt_q;
    assign t_state   = t_q;

endmodule

// File: tb/tb_sap1_controller.sv
// Scoreboard bench for sap1_controller: instruction-level model queues per-cycle expectations, a negedge monitor checks them.
module tb_sap1_controller;

`ifdef SAP1_VAR_CYCLE_EN
    localparam bit VAR_CYCLE = 1'b1;
`else
    localparam bit VAR_CYCLE = 1'b0;
`endif

    // Bench-side strobe bit order
    localparam int S_PC_INC = 0, S_PC_OUT = 1, S_MAR_IN = 2, S_RAM_OUT = 3, S_INSTR_IN = 4, S_INSTR_OUT = 5;
    localparam int S_A_IN = 6, S_A_OUT = 7, S_B_IN = 8, S_ALU_SUB = 9, S_ALU_OUT = 10, S_OUT_IN = 11;

    typedef struct packed {
        logic        rst;
        logic [3:0]  opc;
        logic [11:0] sb;
        logic        hlt;
        logic [5:0]  t;
    } rec_t;

    logic       clk;
    logic       rst;
    logic [3:0] opcode_in;
    logic pc_inc, pc_out, mar_in, ram_out, instr_in, instr_out;
    logic a_in, a_out, b_in, alu_sub, alu_out, out_in, halt;
    logic [5:0] t_state;

    rec_t pend[$];
    rec_t expq[$];
    int   checks   = 0;
    int   failures = 0;

    sap1_controller dut (
        .clk       (clk),
        .rst       (rst),
        .opcode_in (opcode_in),
        .pc_inc    (pc_inc),
        .pc_out    (pc_out),
        .mar_in    (mar_in),
        .ram_out   (ram_out),
        .instr_in  (instr_in),
        .instr_out (instr_out),
        .a_in      (a_in),
        .a_out     (a_out),
        .b_in      (b_in),
        .alu_sub   (alu_sub),
        .alu_out   (alu_out),
        .out_in    (out_in),
        .halt      (halt),
        .t_state   (t_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] bitv(input int i);
        logic [11:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [11:0] fetch_step(input int k);
        case (k)
            0:       return bitv(S_PC_OUT) | bitv(S_MAR_IN);
            1:       return bitv(S_PC_INC);
            default: return bitv(S_RAM_OUT) | bitv(S_INSTR_IN);
        endcase
    endfunction

    // Micro-program for execute step k (0 = T4) of each instruction.
    function automatic logic [11:0] exec_step(input logic [3:0] op, input int k);
        logic [11:0] sub;
        sub = (op == 4'b0010) ? bitv(S_ALU_SUB) : 12'h000;
        if (op == 4'b0000) begin
            if (k == 0) return bitv(S_INSTR_OUT) | bitv(S_MAR_IN);
            if (k == 1) return bitv(S_RAM_OUT) | bitv(S_A_IN);
            return 12'h000;
        end
        if (op == 4'b0001 || op == 4'b0010) begin
            if (k == 0) return bitv(S_INSTR_OUT) | bitv(S_MAR_IN);
            if (k == 1) return bitv(S_RAM_OUT) | bitv(S_B_IN) | sub;
            return bitv(S_ALU_OUT) | bitv(S_A_IN) | sub;
        end
        if (op == 4'b1110 && k == 0) return bitv(S_A_OUT) | bitv(S_OUT_IN);
        return 12'h000;
    endfunction

    task automatic build_instr(input logic [3:0] op, input int hwait, input int rst_at);
        rec_t r;
        int   len;
        for (int k = 0; k < 3; k++) begin
            r.rst = 1'b0;
            r.opc = (k == 2) ? op : 4'($urandom);
            r.sb  = fetch_step(k);
            r.hlt = 1'b0;
            r.t   = 6'(1 << k);
            pend.push_back(r);
        end
        if (op == 4'b1111) begin
            for (int k = 0; k < hwait; k++) begin
                r.rst = 1'b0;
                r.opc = 4'($urandom);
                r.sb  = '0;
                r.hlt = 1'b1;
                r.t   = 6'b001000;
                pend.push_back(r);
            end
            r.rst = 1'b1;
            pend.push_back(r);
        end else begin
            len = (VAR_CYCLE && op != 4'b0000 && op != 4'b0001 && op != 4'b0010) ? 1 : 3;
            for (int k = 0; k < len; k++) begin
                r.rst = (k == rst_at);
                r.opc = 4'($urandom);
                r.sb  = r.rst ? 12'h000 : exec_step(op, k);
                r.hlt = 1'b0;
                r.t   = 6'(8 << k);
                pend.push_back(r);
                if (r.rst) break;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        rec_t e;
        logic [11:0] sb;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            sb = '0;
            sb[S_PC_INC] = pc_inc;      sb[S_PC_OUT] = pc_out;       sb[S_MAR_IN] = mar_in;
            sb[S_RAM_OUT] = ram_out;    sb[S_INSTR_IN] = instr_in;   sb[S_INSTR_OUT] = instr_out;
            sb[S_A_IN] = a_in;          sb[S_A_OUT] = a_out;         sb[S_B_IN] = b_in;
            sb[S_ALU_SUB] = alu_sub;    sb[S_ALU_OUT] = alu_out;     sb[S_OUT_IN] = out_in;
            chk("t_state", 32'(t_state), 32'(e.t));
            chk("halt", 32'(halt), 32'(e.hlt));
            chk("strobes", 32'(sb), 32'(e.sb));
        end
    end

    initial begin
        logic [3:0] dir_ops[8];
        logic [3:0] op;
        rec_t r;
        int   sel;
        dir_ops = '{4'b0000, 4'b0010, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 4'b1110, 4'b0101};

        rst = 1'b1;
        opcode_in = 4'b0000;
        @(posedge clk);
        #1;
        r = '{rst: 1'b1, opc: 4'b0000, sb: 12'h000, hlt: 1'b0, t: 6'b000001};
        expq.push_back(r);

        for (int n = 0; n < 400; n++) begin
            if (n < 8) begin
                op = dir_ops[n];
                build_instr(op, 20, (n == 4) ? 1 : -1);
            end else begin
                sel = $urandom_range(0, 9);
                case (sel)
                    0, 1:    op = 4'b0000;
                    2:       op = 4'b0001;
                    3:       op = 4'b0010;
                    4:       op = 4'b1110;
                    5:       op = 4'b1111;
                    default: op = 4'($urandom);
                endcase
                build_instr(op, $urandom_range(2, 8), -1);
            end
            while (pend.size() > 0) begin
                r = pend.pop_front();
                if (n >= 8 && !r.rst && $urandom_range(0, 39) == 0) begin
                    r.rst = 1'b1;
                    r.sb  = '0;
                end
                if (r.rst) pend.delete();
                @(posedge clk);
                #1;
                rst       = r.rst;
                opcode_in = r.opc;
                expq.push_back(r);
            end
        end

        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(expq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
